vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync-pulse pixels.
REQ-004 Parameter H_BACK, 48, horizontal back-porch pixels.
REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front-porch lines.
REQ-007 Parameter V_SYNC, 2, vertical sync-pulse lines.
REQ-008 Parameter V_BACK, 33, vertical back-porch lines.
REQ-009 clk  input  1  system clock, 50 MHz; the block SHALL use this single clock, with all state on its rising edge.
REQ-010 reset  input  1  the block SHALL use a synchronous, active-high reset.
REQ-011 pixel_x  output  10  current horizontal pixel count, registered.
REQ-012 pixel_y  output  10  current line count, registered.
REQ-013 hsync  output  1  horizontal sync, active low, registered.
REQ-014 vsync  output  1  vertical sync, active low, registered.
REQ-015 video_on  output  1  high when the coordinates are inside the visible area.
REQ-016 p_tick  output  1  pixel-rate enable, one clk wide, clk/2.
REQ-017 frame_start  output  1  one-clk pulse when the counters wrap to (0,0).

Function
REQ-018 The block SHALL toggle p_tick every clk, giving a 25 MHz enable that is high on alternate cycles.
REQ-019 The block SHALL advance pixel_x by 1 only on cycles with p_tick=1.
REQ-020 pixel_x SHALL wrap from H_TOTAL-1 (799) to 0, where H_TOTAL = sum of the H parameters.
REQ-021 pixel_y SHALL increment only on the p_tick on which pixel_x wraps, and SHALL wrap from V_TOTAL-1 (524) to 0.
REQ-022 When pixel_x and pixel_y wrap on the same tick, both SHALL read 0 on the next clk; no intermediate (0,524) or (799,0) value SHALL appear.
REQ-023 hsync SHALL be 0 exactly when pixel_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] ([656,751]), and 1 otherwise.
REQ-024 vsync SHALL be 0 exactly when pixel_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] ([490,491]), and 1 otherwise.
REQ-025 hsync and vsync SHALL be computed from the next-state counter values, so that they are aligned cycle-for-cycle with pixel_x and pixel_y with zero relative latency.
REQ-026 video_on SHALL equal (pixel_x < H_DISPLAY) AND (pixel_y < V_DISPLAY), combinationally from the registered counters.
REQ-027 frame_start SHALL be 1 for exactly one clk: the first cycle on which (pixel_x, pixel_y) = (0,0) after a wrap. It SHALL NOT pulse on the cycle following reset release.
REQ-028 Line period SHALL be 800 ticks (1600 clk); frame period SHALL be 525 lines (840000 clk).
REQ-029 Counter widths SHALL be 10 bits; the parameter sums SHALL be checked at elaboration to be ≤1024.

Reset
REQ-030 While reset=1 at a clk edge, the block SHALL load: tick register = 0, pixel_x = 0, pixel_y = 0, hsync = 1, vsync = 1, frame_start = 0.
REQ-031 The resulting reset-state outputs SHALL be p_tick = 0 and video_on = 1.
REQ-032 Reset asserted mid-frame SHALL take effect on the next clk edge and override any pending wrap.
REQ-033 The first p_tick SHALL occur on the second clk after reset release, and counting SHALL resume from (0,0).

Structure
REQ-034 The timing defaults and the derived H_TOTAL, V_TOTAL, sync start and sync end values SHALL be placed in a shared package, vga_timing_pkg, for use by downstream pixel generators.
REQ-035 The clock-enable divider SHALL be one sub-module, vga_tick_gen (clk, reset -> p_tick); the counters and sync logic SHALL stay in vga_sync.

Verification
REQ-036 Reset scenario: hold reset 3 clk, then release -> pixel_x=0, pixel_y=0, hsync=1, vsync=1, p_tick=0 and video_on=1 during reset; first p_tick on the 2nd clk after release.
REQ-037 Line scenario: run one line -> pixel_x steps 0..799 once per 2 clk; hsync falls when pixel_x becomes 656 and rises when pixel_x becomes 752 (96 ticks low).
REQ-038 Visible-edge scenario: run one line -> video_on=1 at pixel_x=639, 0 at pixel_x=640, 1 again at pixel_x=0; at pixel_y=480, video_on=0 for the whole line.
REQ-039 Frame scenario: run one frame -> vsync=0 exactly for pixel_y 490–491 (1600 ticks); (799,524) -> (0,0) in one step, with a single frame_start pulse; frame length 840000 clk.
REQ-040 Mid-frame reset scenario: assert reset at (700,300) for 1 clk -> next cycle outputs (0,0), hsync=1, vsync=1, frame_start=0.
REQ-041 Every scenario SHALL be checked against a free-running reference counter model over 2 full frames, with 0 mismatches.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and derived values, for vga_sync and downstream pixel generators.
package vga_timing_pkg;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1 << CNT_W;

  typedef logic [CNT_W-1:0] coord_t;

  // 640x480 @ 60 Hz with a 25 MHz pixel rate
  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  function automatic int unsigned timing_total(int unsigned disp, int unsigned front,
                                               int unsigned sync, int unsigned back);
    return disp + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL      = timing_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF,
                                                      H_BACK_DEF);
  localparam int unsigned V_TOTAL      = timing_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF,
                                                      V_BACK_DEF);
  localparam int unsigned H_SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int unsigned V_SYNC_START = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

endpackage

// File: rtl/vga_sync_if.sv
// Video timing bundle: driven by vga_sync (master), read by pixel generators (slave).
interface vga_sync_if;
  import vga_timing_pkg::*;

  coord_t pixel_x;
  coord_t pixel_y;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   p_tick;
  logic   frame_start;

  modport master (
    output pixel_x, pixel_y, hsync, vsync, video_on, p_tick, frame_start
  );

  modport slave (
    input pixel_x, pixel_y, hsync, vsync, video_on, p_tick, frame_start
  );
endinterface

// File: rtl/vga_tick_gen.sv
// Pixel-rate clock enable: high on alternate clk cycles (clk/2).
module vga_tick_gen (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  logic tick_q;

  // Toggle every cycle; reset parks it low so the first enable lands one cycle after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= ~tick_q;
    end
  end

  assign p_tick = tick_q;

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters, registered syncs and frame-start pulse.
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam int unsigned HTotal = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  // Counters are CNT_W bits wide; reject timings that would not fit.
  if (HTotal > CNT_MAX || VTotal > CNT_MAX) begin : g_bad_timing
    $error("vga_sync: H or V total exceeds counter range");
  end

  localparam coord_t HLast      = coord_t'(HTotal - 1);
  localparam coord_t VLast      = coord_t'(VTotal - 1);
  localparam coord_t HDisp      = coord_t'(H_DISPLAY);
  localparam coord_t VDisp      = coord_t'(V_DISPLAY);
  localparam coord_t HSyncStart = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HSyncEnd   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VSyncStart = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VSyncEnd   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic   p_tick;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   frame_start_q, frame_start_d;

  vga_tick_gen u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Next counter values; syncs decode the next state so they land in step with the counters.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (p_tick) begin
      if (x_q == HLast) begin
        x_d = '0;
        if (y_q == VLast) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    hsync_d = !((x_d >= HSyncStart) && (x_d <= HSyncEnd));
    vsync_d = !((y_d >= VSyncStart) && (y_d <= VSyncEnd));
  end

  // State registers; reset overrides any wrap pending on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = (x_q < HDisp) && (y_q < VDisp);
  assign vga.p_tick      = p_tick;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a full 640x480 instance for reset/line/edge behaviour and a reduced-timing
// instance so whole frames, mid-frame resets and random resets fit in a short run.
module tb_vga_sync;

  // Reduced timing for the frame-level instance
  localparam int S_HD = 20, S_HF = 4, S_HS = 6, S_HB = 5;
  localparam int S_VD = 12, S_VF = 2, S_VS = 3, S_VB = 4;
  localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VD + S_VF + S_VS + S_VB;
  localparam int S_FRAME_CLK = 2 * S_HT * S_VT;

  logic   clk = 1'b0;
  logic   rst_full = 1'b1;
  logic   rst_small = 1'b1;
  int     checks = 0;
  int     errors = 0;
  longint c_full = 0;
  longint c_small = 0;

  vga_sync_if bus_full ();
  vga_sync_if bus_small ();

  vga_sync dut_full (
    .clk   (clk),
    .reset (rst_full),
    .vga   (bus_full.master)
  );

  vga_sync #(
    .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
  ) dut_small (
    .clk   (clk),
    .reset (rst_small),
    .vga   (bus_small.master)
  );

  always #10 clk = ~clk;

  // Clock edges elapsed since reset was last seen; the model derives everything from this.
  always @(posedge clk) c_full <= rst_full ? 64'd0 : c_full + 1;
  always @(posedge clk) c_small <= rst_small ? 64'd0 : c_small + 1;

  // Reference: after c edges, c/2 pixel ticks have been consumed; position is that count
  // modulo the frame, split into line and pixel. Returns {x, y, hsync, vsync, von, tick, fs}.
  function automatic logic [24:0] expect_out(longint c, int hd, int hf, int hs, int hb,
                                             int vd, int vf, int vs, int vb);
    longint ht, vt, ticks, t, x, y;
    logic   hsn, vsn, von, pt, fs;
    ht    = hd + hf + hs + hb;
    vt    = vd + vf + vs + vb;
    ticks = c / 2;
    t     = ticks % (ht * vt);
    x     = t % ht;
    y     = t / ht;
    hsn   = !(x >= hd + hf && x < hd + hf + hs);
    vsn   = !(y >= vd + vf && y < vd + vf + vs);
    von   = (x < hd) && (y < vd);
    pt    = (c % 2) == 1;
    fs    = (c > 0) && (c % 2 == 0) && (t == 0);
    return {x[9:0], y[9:0], hsn, vsn, von, pt, fs};
  endfunction

  function automatic logic [24:0] exp_full(longint c);
    return expect_out(c, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [24:0] exp_small(longint c);
    return expect_out(c, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB);
  endfunction

  function automatic logic [24:0] act_full();
    return {bus_full.pixel_x, bus_full.pixel_y, bus_full.hsync, bus_full.vsync,
            bus_full.video_on, bus_full.p_tick, bus_full.frame_start};
  endfunction

  function automatic logic [24:0] act_small();
    return {bus_small.pixel_x, bus_small.pixel_y, bus_small.hsync, bus_small.vsync,
            bus_small.video_on, bus_small.p_tick, bus_small.frame_start};
  endfunction

  // Reset held for 3 clk from time zero, then released; the release cycle counts as clk 1.
  task automatic test_reset();
    rst_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (act_full() !== exp_full(0)) begin
        errors++;
        $display("FAIL reset_hold: got %h expected %h", act_full(), exp_full(0));
      end
    end
    rst_full = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_full.p_tick, bus_full.pixel_x, bus_full.pixel_y, bus_full.frame_start} !==
        {1'b1, 10'd0, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL first_tick: got tick=%b x=%0d y=%0d fs=%b expected tick=1 x=0 y=0 fs=0",
               bus_full.p_tick, bus_full.pixel_x, bus_full.pixel_y, bus_full.frame_start);
    end
    @(negedge clk);
    checks++;
    if ({bus_full.p_tick, bus_full.pixel_x, bus_full.frame_start} !== {1'b0, 10'd1, 1'b0}) begin
      errors++;
      $display("FAIL first_step: got tick=%b x=%0d fs=%b expected tick=0 x=1 fs=0",
               bus_full.p_tick, bus_full.pixel_x, bus_full.frame_start);
    end
  endtask

  task automatic test_line();
    logic        prev_hs;
    int          fall_x = -1;
    int          rise_x = -1;
    int          low_clk = 0;
    logic [24:0] e;
    prev_hs = bus_full.hsync;
    for (int i = 0; i < 1604; i++) begin
      @(negedge clk);
      e = exp_full(c_full);
      checks++;
      if (act_full() !== e) begin
        errors++;
        $display("FAIL line_model: c=%0d got %h expected %h", c_full, act_full(), e);
      end
      if (prev_hs === 1'b1 && bus_full.hsync === 1'b0) fall_x = int'(bus_full.pixel_x);
      if (prev_hs === 1'b0 && bus_full.hsync === 1'b1) rise_x = int'(bus_full.pixel_x);
      if (bus_full.hsync !== 1'b1) low_clk++;
      prev_hs = bus_full.hsync;
    end
    checks++;
    if (fall_x != 656) begin
      errors++;
      $display("FAIL hsync_fall: got x=%0d expected 656", fall_x);
    end
    checks++;
    if (rise_x != 752) begin
      errors++;
      $display("FAIL hsync_rise: got x=%0d expected 752", rise_x);
    end
    checks++;
    if (low_clk != 192) begin
      errors++;
      $display("FAIL hsync_width: got %0d clk expected 192", low_clk);
    end
  endtask

  task automatic test_visible_edge();
    bit seen639 = 0, seen640 = 0, seen0 = 0;
    for (int i = 0; i < 1610 && !seen0; i++) begin
      @(negedge clk);
      if (bus_full.pixel_x == 10'd639 && !seen639) begin
        seen639 = 1;
        checks++;
        if (bus_full.video_on !== 1'b1) begin
          errors++;
          $display("FAIL von_639: got %b expected 1", bus_full.video_on);
        end
      end
      if (bus_full.pixel_x == 10'd640 && seen639 && !seen640) begin
        seen640 = 1;
        checks++;
        if (bus_full.video_on !== 1'b0) begin
          errors++;
          $display("FAIL von_640: got %b expected 0", bus_full.video_on);
        end
      end
      if (bus_full.pixel_x == 10'd0 && seen640) begin
        seen0 = 1;
        checks++;
        if (bus_full.video_on !== 1'b1) begin
          errors++;
          $display("FAIL von_wrap: got %b expected 1", bus_full.video_on);
        end
      end
    end
    checks++;
    if ({seen639, seen640, seen0} !== 3'b111) begin
      errors++;
      $display("FAIL von_edges_seen: got %b expected 111", {seen639, seen640, seen0});
    end
  endtask

  // Two whole reduced frames from reset against the model, plus frame-level properties.
  task automatic test_frame();
    logic [24:0] e;
    int          vs_low = 0, fs_cnt = 0, von_bad = 0, dark_seen = 0;
    longint      fs_at[$];
    logic [9:0]  px, py;
    rst_small = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_small = 1'b0;
    px = bus_small.pixel_x;
    py = bus_small.pixel_y;
    for (int i = 0; i < 2 * S_FRAME_CLK + 4; i++) begin
      @(negedge clk);
      e = exp_small(c_small);
      checks++;
      if (act_small() !== e) begin
        errors++;
        $display("FAIL frame_model: c=%0d got %h expected %h", c_small, act_small(), e);
      end
      if (c_small >= 1 && c_small <= S_FRAME_CLK && bus_small.vsync !== 1'b1) vs_low++;
      if (bus_small.frame_start === 1'b1) begin
        fs_cnt++;
        fs_at.push_back(c_small);
      end
      if (bus_small.pixel_y == 10'(S_VD)) begin
        dark_seen++;
        if (bus_small.video_on !== 1'b0) von_bad++;
      end
      if (px == 10'(S_HT - 1) && py == 10'(S_VT - 1) &&
          (bus_small.pixel_x != px || bus_small.pixel_y != py)) begin
        checks++;
        if ({bus_small.pixel_x, bus_small.pixel_y, bus_small.frame_start} !==
            {10'd0, 10'd0, 1'b1}) begin
          errors++;
          $display("FAIL frame_wrap: got x=%0d y=%0d fs=%b expected x=0 y=0 fs=1",
                   bus_small.pixel_x, bus_small.pixel_y, bus_small.frame_start);
        end
      end
      px = bus_small.pixel_x;
      py = bus_small.pixel_y;
    end
    checks++;
    if (vs_low != S_VS * S_HT * 2) begin
      errors++;
      $display("FAIL vsync_width: got %0d clk expected %0d", vs_low, S_VS * S_HT * 2);
    end
    checks++;
    if (fs_cnt != 2 || fs_at[0] != S_FRAME_CLK || fs_at[1] != 2 * S_FRAME_CLK) begin
      errors++;
      $display("FAIL frame_start_pulses: got %0d pulses first at %0d expected 2 at %0d and %0d",
               fs_cnt, (fs_cnt > 0) ? fs_at[0] : -1, S_FRAME_CLK, 2 * S_FRAME_CLK);
    end
    checks++;
    if (von_bad != 0 || dark_seen == 0) begin
      errors++;
      $display("FAIL dark_line: got %0d lit of %0d samples expected 0 lit", von_bad, dark_seen);
    end
  endtask

  task automatic test_mid_frame_reset();
    bit found = 0;
    for (int i = 0; i < 2 * S_FRAME_CLK && !found; i++) begin
      @(negedge clk);
      if (bus_small.pixel_x == 10'd28 && bus_small.pixel_y == 10'd14) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_reach: got no (28,14) expected it within %0d clk",
               2 * S_FRAME_CLK);
    end
    rst_small = 1'b1;
    @(negedge clk);
    rst_small = 1'b0;
    checks++;
    if ({bus_small.pixel_x, bus_small.pixel_y, bus_small.hsync, bus_small.vsync,
         bus_small.frame_start, bus_small.p_tick} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0})
    begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", act_small(), exp_small(0));
    end
    // Reset on the very tick that would wrap the frame must win over the wrap.
    found = 0;
    for (int i = 0; i < 2 * S_FRAME_CLK && !found; i++) begin
      @(negedge clk);
      if (bus_small.pixel_x == 10'(S_HT - 1) && bus_small.pixel_y == 10'(S_VT - 1) &&
          bus_small.p_tick === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wrap_reset_reach: got no last pixel expected it within %0d clk",
               2 * S_FRAME_CLK);
    end
    rst_small = 1'b1;
    @(negedge clk);
    rst_small = 1'b0;
    checks++;
    if (act_small() !== exp_small(0)) begin
      errors++;
      $display("FAIL wrap_reset: got %h expected %h", act_small(), exp_small(0));
    end
  endtask

  // Random run lengths and random reset pulses, model checked every cycle.
  task automatic test_random_reset();
    logic [24:0] e;
    int          n;
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(50, 600));
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        e = exp_small(c_small);
        checks++;
        if (act_small() !== e) begin
          errors++;
          $display("FAIL rand_run: c=%0d got %h expected %h", c_small, act_small(), e);
        end
      end
      rst_small = 1'b1;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        checks++;
        if (act_small() !== exp_small(0)) begin
          errors++;
          $display("FAIL rand_reset: got %h expected %h", act_small(), exp_small(0));
        end
      end
      rst_small = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_visible_edge();
    test_frame();
    test_mid_frame_reset();
    test_random_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
